// File: rtl/spi_tx.sv
// MSB-first SPI transmitter with registered outputs and an active-low chip select.
// Define SPI_TX_QUEUE_EN to hold one trigger that arrives while a transfer is in progress.
module spi_tx #(
   parameter int unsigned DATA_WIDTH      = 8,
   parameter int unsigned DATA_CLK_PERIOD = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  trigger_in,
   output logic                  data_out,
   output logic                  data_clk_out,
   output logic                  sel_out,
   output logic                  busy_out
);

   localparam int unsigned HALF  = DATA_CLK_PERIOD / 2;
   localparam int unsigned BIT_W = $clog2(DATA_WIDTH) + 1;
   localparam int unsigned PER_W = $clog2(DATA_CLK_PERIOD);

   localparam logic [PER_W-1:0] PER_LAST = PER_W'(DATA_CLK_PERIOD - 1);
   localparam logic [PER_W-1:0] PER_HALF = PER_W'(HALF);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      StIdle,
      StTransmit,
      StEnd
   } state_e;

   state_e                r_state, w_state_nxt;
   logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
   logic [BIT_W-1:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [PER_W-1:0]      r_per_cnt, w_per_cnt_nxt;
   logic                  r_data, w_data_nxt;
   logic                  r_dclk, w_dclk_nxt;
   logic                  r_sel, w_sel_nxt;
   logic                  r_busy, w_busy_nxt;

   logic                  w_start;
   logic [DATA_WIDTH-1:0] w_start_data;

`ifdef SPI_TX_QUEUE_EN
   logic                  r_q_valid, w_q_valid_nxt;
   logic [DATA_WIDTH-1:0] r_q_data, w_q_data_nxt;

   // A held word owns the single IDLE cycle after END; a trigger landing there is dropped.
   always_comb begin
      w_start       = 1'b0;
      w_start_data  = data_in;
      w_q_valid_nxt = r_q_valid;
      w_q_data_nxt  = r_q_data;
      if (r_state == StIdle) begin
         if (r_q_valid) begin
            w_start       = 1'b1;
            w_start_data  = r_q_data;
            w_q_valid_nxt = 1'b0;
         end else if (trigger_in) begin
            w_start = 1'b1;
         end
      end else if (trigger_in && !r_q_valid) begin
         w_q_valid_nxt = 1'b1;
         w_q_data_nxt  = data_in;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_q_valid <= 1'b0;
         r_q_data  <= '0;
      end else begin
         r_q_valid <= w_q_valid_nxt;
         r_q_data  <= w_q_data_nxt;
      end
   end
`else
   assign w_start      = trigger_in && (r_state == StIdle);
   assign w_start_data = data_in;
`endif

   always_comb begin
      w_state_nxt   = r_state;
      w_shift_nxt   = r_shift;
      w_bit_cnt_nxt = r_bit_cnt;
      w_per_cnt_nxt = r_per_cnt;
      w_data_nxt    = r_data;
      w_dclk_nxt    = 1'b0;
      w_sel_nxt     = 1'b0;
      w_busy_nxt    = 1'b1;
      unique case (r_state)
         StIdle: begin
            w_sel_nxt     = 1'b1;
            w_busy_nxt    = 1'b0;
            w_data_nxt    = 1'b0;
            w_bit_cnt_nxt = '0;
            w_per_cnt_nxt = '0;
            if (w_start) begin
               w_state_nxt = StTransmit;
               w_shift_nxt = w_start_data;
               w_data_nxt  = w_start_data[DATA_WIDTH-1];
               w_sel_nxt   = 1'b0;
               w_busy_nxt  = 1'b1;
            end
         end
         StTransmit: begin
            if (r_per_cnt == PER_LAST) begin
               w_per_cnt_nxt = '0;
               if (r_bit_cnt == BIT_LAST) begin
                  w_state_nxt = StEnd;
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
                  w_shift_nxt   = r_shift << 1;
                  w_data_nxt    = w_shift_nxt[DATA_WIDTH-1];
               end
            end else begin
               w_per_cnt_nxt = r_per_cnt + PER_W'(1);
               w_dclk_nxt    = (w_per_cnt_nxt >= PER_HALF);
            end
         end
         StEnd: begin
            w_state_nxt   = StIdle;
            w_shift_nxt   = '0;
            w_bit_cnt_nxt = '0;
            w_per_cnt_nxt = '0;
            w_data_nxt    = 1'b0;
            w_sel_nxt     = 1'b1;
            w_busy_nxt    = 1'b0;
         end
         default: begin
            w_state_nxt = StIdle;
            w_data_nxt  = 1'b0;
            w_sel_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state   <= StIdle;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_per_cnt <= '0;
         r_data    <= 1'b0;
         r_dclk    <= 1'b0;
         r_sel     <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_shift   <= w_shift_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_per_cnt <= w_per_cnt_nxt;
         r_data    <= w_data_nxt;
         r_dclk    <= w_dclk_nxt;
         r_sel     <= w_sel_nxt;
         r_busy    <= w_busy_nxt;
      end
   end

   assign data_out     = r_data;
   assign data_clk_out = r_dclk;
   assign sel_out      = r_sel;
   assign busy_out     = r_busy;

endmodule

// File: tb/tb_spi_tx.sv
// Self-checking bench for spi_tx: a receiving monitor feeds a word scoreboard while each
// scenario task checks cycle-level timing inline.
module tb_spi_tx;

   logic       clk_in     = 1'b0;
   logic       rst_in     = 1'b1;
   logic       trigger_in = 1'b0;
   logic [7:0] data_in    = 8'h00;
   logic       data_out, data_clk_out, sel_out, busy_out;

   logic       s_trigger = 1'b0;
   logic [0:0] s_data_in = 1'b0;
   logic       s_data_out, s_dclk, s_sel, s_busy;

   int         n_checks = 0;
   int         n_fail   = 0;
   int         m_words  = 0;
   logic [7:0] exp_q[$];

   always #5 clk_in = ~clk_in;

   spi_tx #(
      .DATA_WIDTH     (8),
      .DATA_CLK_PERIOD(4)
   ) u_dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .data_in     (data_in),
      .trigger_in  (trigger_in),
      .data_out    (data_out),
      .data_clk_out(data_clk_out),
      .sel_out     (sel_out),
      .busy_out    (busy_out)
   );

   spi_tx #(
      .DATA_WIDTH     (1),
      .DATA_CLK_PERIOD(2)
   ) u_dut_small (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .data_in     (s_data_in),
      .trigger_in  (s_trigger),
      .data_out    (s_data_out),
      .data_clk_out(s_dclk),
      .sel_out     (s_sel),
      .busy_out    (s_busy)
   );

   // Receiver model: shifts data_out in on each data_clk_out rise, closes a word when sel_out rises.
   initial begin : monitor
      logic       prev_dclk, prev_data, prev_sel;
      logic [7:0] word, exp;
      int         bits;
      prev_dclk = 1'b0;
      prev_data = 1'b0;
      prev_sel  = 1'b1;
      word      = 8'h00;
      exp       = 8'h00;
      bits      = 0;
      forever begin
         @(negedge clk_in);
         #1;
         if (rst_in) begin
            bits = 0;
         end else begin
            if (data_clk_out === 1'b1 && prev_dclk === 1'b1) begin
               n_checks++;
               if (data_out !== prev_data) begin
                  n_fail++;
                  $display("FAIL data_stable: data_out=%b while data_clk_out high, required %b",
                           data_out, prev_data);
               end
            end
            if (data_clk_out === 1'b1 && prev_dclk === 1'b0) begin
               word = {word[6:0], data_out};
               bits++;
            end
            if (sel_out === 1'b1 && prev_sel === 1'b0 && bits > 0) begin
               n_checks++;
               m_words++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL scoreboard: got word %h (%0d bits), required no word", word, bits);
               end else begin
                  exp = exp_q.pop_front();
                  if (bits != 8 || word !== exp) begin
                     n_fail++;
                     $display("FAIL scoreboard: got word %h (%0d bits), required %h (8 bits)",
                              word, bits, exp);
                  end
               end
               bits = 0;
            end
         end
         prev_dclk = data_clk_out;
         prev_data = data_out;
         prev_sel  = sel_out;
      end
   end

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (2) @(posedge clk_in);
      #1;
      trigger_in = 1'b1;
      data_in    = 8'hFF;
      @(negedge clk_in);
      n_checks++;
      if ({busy_out, sel_out, data_clk_out, data_out} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_idle: {busy,sel,clk,data}=%b required 0100",
                  {busy_out, sel_out, data_clk_out, data_out});
      end
      n_checks++;
      if ({s_busy, s_sel, s_dclk, s_data_out} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_idle_small: {busy,sel,clk,data}=%b required 0100",
                  {s_busy, s_sel, s_dclk, s_data_out});
      end
      @(posedge clk_in);
      @(negedge clk_in);
      n_checks++;
      if ({busy_out, sel_out} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_priority: {busy,sel}=%b required 01", {busy_out, sel_out});
      end
      trigger_in = 1'b0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
   endtask

   task automatic test_basic();
      logic [7:0] word;
      logic [3:0] e;
      int         n_busy, n_sel_low;
      word      = 8'hA5;
      n_busy    = 0;
      n_sel_low = 0;
      exp_q.push_back(word);
      @(posedge clk_in);
      #1;
      data_in    = word;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      data_in    = 8'h00;
      for (int i = 1; i <= 34; i++) begin
         @(negedge clk_in);
         data_in = 8'($urandom);
         if (i <= 32)      e = {1'b1, 1'b0, ((i - 1) % 4) >= 2, word[7 - (i - 1) / 4]};
         else if (i == 33) e = {1'b1, 1'b0, 1'b0, word[0]};
         else              e = 4'b0100;
         n_busy    += int'(busy_out);
         n_sel_low += int'(!sel_out);
         n_checks++;
         if ({busy_out, sel_out, data_clk_out, data_out} !== e) begin
            n_fail++;
            $display("FAIL basic_cycle%0d: {busy,sel,clk,data}=%b required %b", i,
                     {busy_out, sel_out, data_clk_out, data_out}, e);
         end
      end
      n_checks++;
      if (n_busy != 33) begin
         n_fail++;
         $display("FAIL basic_busy_len: got %0d cycles required 33", n_busy);
      end
      n_checks++;
      if (n_sel_low != 33) begin
         n_fail++;
         $display("FAIL basic_sel_len: got %0d cycles required 33", n_sel_low);
      end
      repeat (3) @(negedge clk_in);
   endtask

   task automatic test_loopback();
      int m_before;
      int i;
      m_before = m_words;
      exp_q.push_back(8'h3C);
      @(posedge clk_in);
      #1;
      data_in    = 8'h3C;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      for (i = 0; i < 60; i++) begin
         @(negedge clk_in);
         if (!busy_out) break;
      end
      n_checks++;
      if (i >= 60) begin
         n_fail++;
         $display("FAIL loopback_timeout: busy_out=%b after 60 cycles required 0", busy_out);
      end
      repeat (2) @(negedge clk_in);
      n_checks++;
      if (m_words != m_before + 1 || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL loopback_words: got %0d words (%0d pending) required 1 (0 pending)",
                  m_words - m_before, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int   rises, i;
      logic prev;
      rises = 0;
      prev  = 1'b0;
      @(posedge clk_in);
      #1;
      data_in    = 8'hFF;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      for (i = 0; i < 40 && rises < 4; i++) begin
         @(negedge clk_in);
         if (data_clk_out && !prev) rises++;
         prev = data_clk_out;
      end
      n_checks++;
      if (rises != 4) begin
         n_fail++;
         $display("FAIL reset_mid_rises: got %0d clock rises required 4", rises);
      end
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if ({busy_out, sel_out, data_clk_out, data_out} !== 4'b0100) begin
         n_fail++;
         $display("FAIL reset_mid_idle: {busy,sel,clk,data}=%b required 0100",
                  {busy_out, sel_out, data_clk_out, data_out});
      end
      exp_q.push_back(8'h81);
      data_in    = 8'h81;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if ({busy_out, sel_out, data_clk_out, data_out} !== 4'b1001) begin
         n_fail++;
         $display("FAIL reset_mid_restart: {busy,sel,clk,data}=%b required 1001",
                  {busy_out, sel_out, data_clk_out, data_out});
      end
      for (i = 0; i < 60; i++) begin
         @(negedge clk_in);
         if (!busy_out) break;
      end
      repeat (2) @(negedge clk_in);
      n_checks++;
      if (exp_q.size() != 0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_0x81: pending=%0d busy=%b required pending=0 busy=0",
                  exp_q.size(), busy_out);
      end
   endtask

   task automatic test_busy_trigger();
      int   n_busy, gap_run, gap_total;
      bit   seen_low;
      int   exp_busy, exp_gap;
      n_busy    = 0;
      gap_run   = 0;
      gap_total = 0;
      seen_low  = 1'b0;
      exp_q.push_back(8'h12);
`ifdef SPI_TX_QUEUE_EN
      exp_q.push_back(8'h34);
      exp_busy = 66;
      exp_gap  = 1;
`else
      exp_busy = 33;
      exp_gap  = 0;
`endif
      @(posedge clk_in);
      #1;
      data_in    = 8'h12;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk_in);
         n_busy += int'(busy_out);
         if (!sel_out) begin
            if (seen_low) gap_total += gap_run;
            gap_run  = 0;
            seen_low = 1'b1;
         end else if (seen_low) begin
            gap_run++;
         end
         trigger_in = (i == 10) || (i == 12);
         if (i == 10) data_in = 8'h34;
         if (i == 12) data_in = 8'h56;
      end
      n_checks++;
      if (n_busy != exp_busy) begin
         n_fail++;
         $display("FAIL busy_trigger_len: busy %0d cycles required %0d", n_busy, exp_busy);
      end
      n_checks++;
      if (gap_total != exp_gap) begin
         n_fail++;
         $display("FAIL busy_trigger_gap: sel high %0d cycles between words required %0d",
                  gap_total, exp_gap);
      end
      n_checks++;
      if (exp_q.size() != 0 || busy_out !== 1'b0) begin
         n_fail++;
         $display("FAIL busy_trigger_words: pending=%0d busy=%b required pending=0 busy=0",
                  exp_q.size(), busy_out);
      end
   endtask

   task automatic test_back_to_back();
      int i;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hC3);
      @(posedge clk_in);
      #1;
      data_in    = 8'h5A;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      for (i = 0; i < 60; i++) begin
         @(negedge clk_in);
         if (!busy_out) break;
      end
      n_checks++;
      if (sel_out !== 1'b1 || i >= 60) begin
         n_fail++;
         $display("FAIL b2b_gap: sel=%b after %0d cycles required sel=1 within 60", sel_out, i);
      end
      data_in    = 8'hC3;
      trigger_in = 1'b1;
      @(posedge clk_in);
      #1;
      trigger_in = 1'b0;
      @(negedge clk_in);
      n_checks++;
      if ({busy_out, sel_out, data_clk_out, data_out} !== 4'b1001) begin
         n_fail++;
         $display("FAIL b2b_start: {busy,sel,clk,data}=%b required 1001",
                  {busy_out, sel_out, data_clk_out, data_out});
      end
      for (i = 0; i < 60; i++) begin
         @(negedge clk_in);
         if (!busy_out) break;
      end
      repeat (2) @(negedge clk_in);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL b2b_words: pending=%0d required 0", exp_q.size());
      end
   endtask

   task automatic test_small();
      logic [3:0] e;
      int         n_busy, n_rise;
      logic       prev;
      n_busy = 0;
      n_rise = 0;
      prev   = 1'b0;
      @(posedge clk_in);
      #1;
      s_data_in = 1'b1;
      s_trigger = 1'b1;
      @(posedge clk_in);
      #1;
      s_trigger = 1'b0;
      s_data_in = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk_in);
         unique case (i)
            1, 3:    e = 4'b1001;
            2:       e = 4'b1011;
            default: e = 4'b0100;
         endcase
         n_busy += int'(s_busy);
         if (s_dclk && !prev && s_data_out) n_rise++;
         prev = s_dclk;
         n_checks++;
         if ({s_busy, s_sel, s_dclk, s_data_out} !== e) begin
            n_fail++;
            $display("FAIL small_cycle%0d: {busy,sel,clk,data}=%b required %b", i,
                     {s_busy, s_sel, s_dclk, s_data_out}, e);
         end
      end
      n_checks++;
      if (n_busy != 3 || n_rise != 1) begin
         n_fail++;
         $display("FAIL small_len: busy %0d cycles, %0d rises with data=1, required 3 and 1",
                  n_busy, n_rise);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_loopback();
      test_reset_mid();
      test_busy_trigger();
      test_back_to_back();
      test_small();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_in);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL final_drain: %0d words pending required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_tx.md
SPI_TX -- requirements
Module: spi_tx

Interface
REQ-001 Parameter DATA_WIDTH, default 8: bits per transfer; SHALL be >= 1.
REQ-002 Parameter DATA_CLK_PERIOD, default 4: system-clock cycles per serial bit; SHALL be even and >= 2; HALF = DATA_CLK_PERIOD/2.
REQ-003 clk_in  input  1: single system clock; all logic on its rising edge.
REQ-004 rst_in  input  1: reset, synchronous, active-high.
REQ-005 data_in  input  DATA_WIDTH: parallel word, sampled only on an accepted trigger.
REQ-006 trigger_in  input  1: single-cycle start request.
REQ-007 data_out  output  1: serial data line, MSB first.
REQ-008 data_clk_out  output  1: serial clock; receiver samples on its rising edge.
REQ-009 sel_out  output  1: chip select, active-low (0 = transfer in progress).
REQ-010 busy_out  output  1: high while a transfer is in progress.

Function
REQ-011 States: IDLE, TRANSMIT, END; shift register DATA_WIDTH bits; bit counter $clog2(DATA_WIDTH)+1 bits; period counter $clog2(DATA_CLK_PERIOD) bits.
REQ-012 IDLE outputs: sel_out=1, data_clk_out=0, data_out=0, busy_out=0.
REQ-013 trigger_in=1 in IDLE at edge t SHALL latch data_in and, from cycle t+1, give sel_out=0, busy_out=1, data_out=data_in[DATA_WIDTH-1], data_clk_out=0 (state TRANSMIT).
REQ-014 Each bit period: data_clk_out low for HALF cycles, then high for HALF cycles; bit k (k=0 for MSB) rising edge at cycle t+1+HALF+k*DATA_CLK_PERIOD.
REQ-015 data_out SHALL change only when data_clk_out goes low (start of a bit period), never while data_clk_out=1.
REQ-016 After the high half of bit DATA_WIDTH-1, state END for exactly one cycle: data_clk_out=0, sel_out=0, busy_out=1, data_out holds the last bit.
REQ-017 After END, state IDLE; busy_out is high for exactly DATA_WIDTH*DATA_CLK_PERIOD+1 cycles per transfer.
REQ-018 sel_out SHALL be high for at least one cycle between consecutive transfers.
REQ-019 Input data_in changes after acceptance SHALL not affect the transfer in progress.
REQ-020 trigger_in while busy_out=1 (TRANSMIT or END) is handled per REQ-024/REQ-025; it never restarts or corrupts the current transfer.
REQ-021 Outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-022 rst_in=1 at any edge, including mid-transfer, SHALL on the next cycle force IDLE outputs (REQ-012), clear all counters and shift register, and drop any queued word; rst_in has priority over trigger_in.
REQ-023 The first trigger accepted after reset deasserts behaves exactly as REQ-013.

Configuration
REQ-024 Macro SPI_TX_QUEUE_EN undefined: trigger_in while busy_out=1 is ignored.
REQ-025 SPI_TX_QUEUE_EN defined: one-entry holding register; trigger_in while busy_out=1 and queue empty captures data_in; triggers while queue full are dropped; a queued word starts exactly as REQ-013 from the single IDLE cycle after END (sel_out=1 for exactly one cycle); a trigger coincident with that start-from-queue is dropped.

Verification
REQ-026 DATA_WIDTH=8, DATA_CLK_PERIOD=4, trigger with 0xA5 -> data_out at rising edges 1,0,1,0,0,1,0,1; busy_out high 33 cycles; sel_out low 33 cycles.
REQ-027 Loopback into the team's SPI receiver (same DATA_WIDTH), send 0x3C -> receiver new_data_out pulses once with data_out=0x3C.
REQ-028 rst_in pulsed after bit 3 of 0xFF -> next cycle sel_out=1, data_clk_out=0, busy_out=0; subsequent trigger with 0x81 transfers 0x81 cleanly.
REQ-029 Without SPI_TX_QUEUE_EN: 0x12 then trigger 0x34 at cycle 10 -> only 0x12 sent; IDLE after 33 cycles.
REQ-030 With SPI_TX_QUEUE_EN: 0x12 then triggers 0x34 (cycle 10) and 0x56 (cycle 12) -> 0x12, one cycle sel_out=1, 0x34; 0x56 dropped.
REQ-031 DATA_CLK_PERIOD=2, DATA_WIDTH=1, trigger with 1 -> busy_out high 3 cycles, one rising edge with data_out=1.
